sequential_left_shift_by_amount: RTL and testbench

- Multi-cycle counterpart to the combinational right shifters: a logical left shift of an N-bit operand by a run-time amount.
- Shifts STEP bit positions per clock, with a valid/ready handshake on both the input and output side.
- Serves as the sequential arithmetic building block for later exercises, where area matters more than latency.

---
 rtl/sequential_shift_pkg.sv | 16 +
 rtl/left_shift_step.sv | 28 ++
 rtl/sequential_left_shift_by_amount.sv | 91 +++++++++
 tb/tb_sequential_left_shift_by_amount.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sequential_shift_pkg.sv
// Shared types and helpers for the sequential left shifter.
// Optional rotate mode is enabled by defining SEQ_SHIFT_ROTATE_EN.
package sequential_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bits to move this clock: never more than STEP, never past the remaining count.
    function automatic int calc_step(input int remaining, input int step_max);
        return (remaining < step_max) ? remaining : step_max;
    endfunction

endpackage

// File: rtl/left_shift_step.sv
// Combinational left shift (or rotate with SEQ_SHIFT_ROTATE_EN) by 0..STEP positions.
// Only STEP+1 candidate results exist, so this stays a small mux rather than a full barrel.
module left_shift_step #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic [N-1:0]         data,
    input  logic [$clog2(N)-1:0] amt,
`ifdef SEQ_SHIFT_ROTATE_EN
    input  logic                 rotate,
`endif
    output logic [N-1:0]         result
);

    always_comb begin
        result = data;
        for (int i = 1; i <= STEP; i++) begin
            if (int'(amt) == i) begin
`ifdef SEQ_SHIFT_ROTATE_EN
                result = rotate ? ((data << i) | (data >> (N - i))) : (data << i);
`else
                result = data << i;
`endif
            end
        end
    end

endmodule

// File: rtl/sequential_left_shift_by_amount.sv
// Multi-cycle logical left shift by a run-time amount, STEP bits per clock, valid/ready on both sides.
// Define SEQ_SHIFT_ROTATE_EN to add the in_rotate port and rotate mode.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand
// SHIFT | stepping the result left, remaining count down to zero
// DONE  | out_valid high, result held until out_ready
module sequential_left_shift_by_amount #(
    parameter int N    = 8,
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
`ifdef SEQ_SHIFT_ROTATE_EN
    input  logic                 in_rotate,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data
);
    import sequential_shift_pkg::*;

    localparam int W = $clog2(N);

    state_t         state, state_nxt;
    logic [N-1:0]   result, result_step;
    logic [W-1:0]   remaining, step_amt;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic           rotate_q;
`endif

    assign step_amt = W'(calc_step(32'(remaining), STEP));

    left_shift_step #(.N(N), .STEP(STEP)) u_step (
        .data   (result),
        .amt    (step_amt),
`ifdef SEQ_SHIFT_ROTATE_EN
        .rotate (rotate_q),
`endif
        .result (result_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            result    <= '0;
            remaining <= '0;
`ifdef SEQ_SHIFT_ROTATE_EN
            rotate_q  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        result    <= in_data;
                        remaining <= in_shamt;
`ifdef SEQ_SHIFT_ROTATE_EN
                        rotate_q  <= in_rotate;
`endif
                    end
                end
                SHIFT: begin
                    result    <= result_step;
                    remaining <= remaining - step_amt;
                end
                default: ;
            endcase
        end
    end

    // Handshake flags come from state alone so in_ready never follows out_ready combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) state_nxt = (in_shamt == '0) ? DONE : SHIFT;
            SHIFT:   if (remaining == step_amt) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_data = result;

endmodule

// File: tb/tb_sequential_left_shift_by_amount.sv
// Scoreboard bench for sequential_left_shift_by_amount (STEP=2); rotate cases need SEQ_SHIFT_ROTATE_EN.
module tb_sequential_left_shift_by_amount;

    localparam int N    = 8;
    localparam int STEP = 2;
    localparam int W    = $clog2(N);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic [W-1:0] in_shamt;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic         in_rotate;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;

    sequential_left_shift_by_amount #(.N(N), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
`ifdef SEQ_SHIFT_ROTATE_EN
        .in_rotate (in_rotate),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] data;
        int           c0;
        int           lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rand_rdy = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Reference: multiply by 2**sh in a double-width word; the upper half holds the bits that fell off.
    function automatic logic [N-1:0] ref_model(input logic [N-1:0] d, input int sh, input bit rot);
        logic [2*N-1:0] wide;
        wide = (2*N)'(d) * (2*N)'(1 << sh);
        return rot ? (wide[N-1:0] | wide[2*N-1:N]) : wide[N-1:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            chk("in_ready_in_done", int'(in_ready), 0);
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc, q[0].c0 + q[0].lat);
                    seen = 1;
                end
                chk("out_data", int'(out_data), int'(q[0].data));
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [N-1:0] d, input int sh, input bit rot);
        exp_t e;
        in_data  = d;
        in_shamt = W'(sh);
`ifdef SEQ_SHIFT_ROTATE_EN
        in_rotate = rot;
`endif
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                e.data = ref_model(d, sh, rot);
                e.c0   = cyc;
                e.lat  = (sh + STEP - 1) / STEP;
                q.push_back(e);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 1, 0);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400; t++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0) return;
        end
        chk("drain_timeout", q.size(), 0);
        q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
`ifdef SEQ_SHIFT_ROTATE_EN
        in_rotate = 1'b0;
`endif
        out_ready = 1'b0;
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        issue(8'hB3, 3, 0);
        wait_drain();
        chk("in_ready_after_done", int'(in_ready), 1);

        issue(8'h01, 5, 0);
        wait_drain();
        issue(8'h5A, 0, 0);
        wait_drain();

        // Backpressure: hold the result while stray in_valid pulses arrive.
        out_ready = 1'b0;
        issue(8'hB3, 3, 0);
        for (int t = 0; t < 50 && !out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        for (int t = 0; t < 10; t++) begin
            in_data  = 8'hFF;
            in_shamt = W'(1);
            in_valid = 1'(t % 2);
            @(posedge clk);
            #1;
            chk("bp_valid_held", int'(out_valid), 1);
            chk("bp_data_held", int'(out_data), 8'h98);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_release_valid", int'(out_valid), 0);
        chk("bp_release_queue", q.size(), 0);

        // Asynchronous reset in the middle of a long shift.
        issue(8'hC5, 7, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_data", int'(out_data), 0);
        chk("midreset_in_ready", int'(in_ready), 1);
        q.delete();
        seen = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(8'h81, 1, 0);
        wait_drain();

`ifdef SEQ_SHIFT_ROTATE_EN
        issue(8'hB3, 3, 1);
        wait_drain();
        issue(8'hB3, 3, 0);
        wait_drain();
`endif

        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            bit rot;
            rot = 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
            rot = 1'($urandom_range(0, 1));
`endif
            issue(N'($urandom), int'($urandom_range(0, N - 1)), rot);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        wait_drain();
        rand_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
